// File: rtl/wb_uart_tx_if.sv
// CPU data-bus request into the UART and the xbus response returned to the CPU.
interface wb_uart_tx_if;
  logic [31:0] wb_dbus_adr;
  logic [31:0] wb_dbus_dat;
  logic [3:0]  wb_dbus_sel;
  logic        wb_dbus_we;
  logic        wb_dbus_cyc;
  logic [31:0] wb_xbus_rdt;
  logic        wb_xbus_ack;

  modport master (
    output wb_dbus_adr, wb_dbus_dat, wb_dbus_sel, wb_dbus_we, wb_dbus_cyc,
    input  wb_xbus_rdt, wb_xbus_ack
  );

  modport slave (
    input  wb_dbus_adr, wb_dbus_dat, wb_dbus_sel, wb_dbus_we, wb_dbus_cyc,
    output wb_xbus_rdt, wb_xbus_ack
  );
endinterface

// File: rtl/wb_uart_tx.sv
// Wishbone UART transmitter: byte FIFO feeding an 8N1 shifter; registered ack one cycle after cyc.
// No bus stall: ack always given, pushes into a full FIFO are dropped and flagged as overflow.
module wb_uart_tx #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] ADDR        = 4'h4,
  parameter int               FIFO_DEPTH  = 16,
  parameter logic [15:0]      DEFAULT_DIV = 16'd104
) (
  input  logic         wb_clk,
  input  logic         wb_rst_n,
  wb_uart_tx_if.slave  bus,
  output logic         tx,
  output logic         irq_empty
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  typedef struct packed {
    logic [14:0] rsv_hi;
    logic        ovf;
    logic [3:0]  rsv_lo;
    logic        busy;
    logic        full;
    logic        empty;
    logic [8:0]  count;
  } status_t;

  state_e        state_d, state_q;
  logic          ack_d, ack_q, held_d, held_q;
  logic [31:0]   rdt_d, rdt_q;
  logic [AW-1:0] wptr_d, wptr_q, rptr_d, rptr_q;
  logic [CW-1:0] count_d, count_q;
  logic          ovf_d, ovf_q;
  logic [15:0]   div_d, div_q, cnt_d, cnt_q, eff_div;
  logic [7:0]    sh_d, sh_q;
  logic [2:0]    idx_d, idx_q;
  logic          tx_d, tx_q, irq_d, irq_q;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic          sel_hit, wr, push_req, push_ok, pop, full, empty, bit_end;
  logic [1:0]    off;
  status_t       status;
  logic          unused_bits;

  assign sel_hit = bus.wb_dbus_cyc && (bus.wb_dbus_adr[31:32-WIDTH] == ADDR);
  assign off     = bus.wb_dbus_adr[3:2];
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign eff_div = (div_q < 16'd2) ? 16'd2 : div_q;
  assign bit_end = (cnt_q == 16'd0);
  assign unused_bits = ^{bus.wb_dbus_adr, bus.wb_dbus_dat, bus.wb_dbus_sel};

  // Serialiser; the baud counter reloads at every bit boundary from the current divisor.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    if (state_q != S_IDLE) cnt_d = bit_end ? (eff_div - 16'd1) : (cnt_q - 16'd1);
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = fifo_mem[rptr_q];
          cnt_d   = eff_div - 16'd1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          idx_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
          end
        end
      end
      default: begin
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            sh_d    = fifo_mem[rptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
    endcase
    tx_d = 1'b1;
    if (state_d == S_START)     tx_d = 1'b0;
    else if (state_d == S_DATA) tx_d = sh_d[0];
  end

  // Bus side; held_q blocks a second ack while the initiator keeps cyc asserted.
  always_comb begin
    ack_d  = sel_hit && !ack_q && !held_q;
    held_d = held_q;
    if (ack_d)                   held_d = 1'b1;
    else if (!bus.wb_dbus_cyc)   held_d = 1'b0;
    wr = ack_d && bus.wb_dbus_we;

    status       = '0;
    status.count = 9'(count_q);
    status.empty = empty;
    status.full  = full;
    status.busy  = (state_q != S_IDLE);
    status.ovf   = ovf_q;

    rdt_d = '0;
    if (ack_d) begin
      case (off)
        2'd1:    rdt_d = status;
        2'd2:    rdt_d = {16'b0, div_q};
        default: rdt_d = '0;
      endcase
    end

    push_req = wr && (off == 2'd0) && bus.wb_dbus_sel[0];
    push_ok  = push_req && (!full || pop);

    ovf_d = ovf_q;
    if (push_req && full && !pop) ovf_d = 1'b1;
    if (wr && (off == 2'd1) && bus.wb_dbus_sel[2] && bus.wb_dbus_dat[16]) ovf_d = 1'b0;

    div_d = div_q;
    if (wr && (off == 2'd2)) begin
      if (bus.wb_dbus_sel[0]) div_d[7:0]  = bus.wb_dbus_dat[7:0];
      if (bus.wb_dbus_sel[1]) div_d[15:8] = bus.wb_dbus_dat[15:8];
    end

    wptr_d  = wptr_q + AW'(push_ok);
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);

    irq_d = (count_d == '0) && (state_d == S_IDLE);
  end

  always_ff @(posedge wb_clk) begin
    if (push_ok) fifo_mem[wptr_q] <= bus.wb_dbus_dat[7:0];
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      held_q  <= 1'b0;
      rdt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      div_q   <= DEFAULT_DIV;
      cnt_q   <= '0;
      sh_q    <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      irq_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      held_q  <= held_d;
      rdt_q   <= rdt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.wb_xbus_ack = ack_q;
  assign bus.wb_xbus_rdt = rdt_q;
  assign tx              = tx_q;
  assign irq_empty       = irq_q;

endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed + randomized bench for wb_uart_tx; expected UART waveforms come from a frame-level model.
module tb_wb_uart_tx;
  localparam logic [31:0] A_TX   = 32'h4000_0000;
  localparam logic [31:0] A_STAT = 32'h4000_0004;
  localparam logic [31:0] A_DIV  = 32'h4000_0008;

  logic wb_clk, wb_rst_n, tx, irq_empty;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] unused_rd;
  logic [7:0]  exp_bytes[$];
  int          exp_lens[$];

  wb_uart_tx_if bus_if();

  wb_uart_tx #(.WIDTH(4), .ADDR(4'h4), .FIFO_DEPTH(16), .DEFAULT_DIV(16'd104)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .bus(bus_if), .tx(tx), .irq_empty(irq_empty)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One bus transfer; returns one tick after the acking edge with cyc already dropped.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r);
    int n;
    @(posedge wb_clk); #1;
    bus_if.wb_dbus_adr = a;
    bus_if.wb_dbus_dat = d;
    bus_if.wb_dbus_sel = s;
    bus_if.wb_dbus_we  = w;
    bus_if.wb_dbus_cyc = 1'b1;
    n = 0;
    do begin
      @(posedge wb_clk); #1;
      n++;
    end while (!bus_if.wb_xbus_ack && n < 8);
    r = bus_if.wb_xbus_rdt;
    bus_if.wb_dbus_cyc = 1'b0;
    bus_if.wb_dbus_we  = 1'b0;
    check("ack_latency", 32'(n), 32'd1);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] v;
    bus(1'b0, a, 32'h0, 4'hF, v);
    check(tag, v, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus(1'b1, a, d, s, unused_rd);
  endtask

  task automatic miss(input logic [31:0] a, input logic w);
    logic acks;
    logic [31:0] rdts;
    @(posedge wb_clk); #1;
    bus_if.wb_dbus_adr = a;
    bus_if.wb_dbus_dat = 32'h0000_0055;
    bus_if.wb_dbus_sel = 4'hF;
    bus_if.wb_dbus_we  = w;
    bus_if.wb_dbus_cyc = 1'b1;
    acks = 1'b0;
    rdts = '0;
    repeat (4) begin
      @(posedge wb_clk); #1;
      acks |= bus_if.wb_xbus_ack;
      rdts |= bus_if.wb_xbus_rdt;
    end
    bus_if.wb_dbus_cyc = 1'b0;
    bus_if.wb_dbus_we  = 1'b0;
    check("miss_ack", 32'(acks), 32'd0);
    check("miss_rdt", rdts, 32'd0);
  endtask

  function automatic int eff(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic add_frame(input logic [7:0] b, input int len);
    exp_bytes.push_back(b);
    repeat (10) exp_lens.push_back(len);
  endtask

  // Each bit must hold its expected level for every clock of its expected length.
  task automatic check_stream();
    logic [9:0] frame, or_v, and_v;
    logic irq_seen, o, a;
    for (int f = 0; f < exp_bytes.size(); f++) begin
      frame    = {1'b1, exp_bytes[f], 1'b0};
      or_v     = '0;
      and_v    = '1;
      irq_seen = 1'b0;
      for (int b = 0; b < 10; b++) begin
        o = 1'b0;
        a = 1'b1;
        for (int c = 0; c < exp_lens[f*10+b]; c++) begin
          @(posedge wb_clk); #1;
          o |= tx;
          a &= tx;
          irq_seen |= irq_empty;
        end
        or_v[b]  = o;
        and_v[b] = a;
      end
      check("frame_or", 32'(or_v), 32'(frame));
      check("frame_and", 32'(and_v), 32'(frame));
      check("irq_during_frame", 32'(irq_seen), 32'd0);
    end
    @(posedge wb_clk); #1;
    check("tx_idle_after", 32'(tx), 32'd1);
    check("irq_after_stop", 32'(irq_empty), 32'd1);
  endtask

  initial begin
    int pulses, d, n;
    logic [31:0] rdt_at, rdt_idle;
    logic [7:0] b;
    logic [7:0] bq[4];

    bus_if.wb_dbus_adr = '0;
    bus_if.wb_dbus_dat = '0;
    bus_if.wb_dbus_sel = '0;
    bus_if.wb_dbus_we  = 1'b0;
    bus_if.wb_dbus_cyc = 1'b0;
    wb_rst_n = 1'b0;
    repeat (3) @(posedge wb_clk);
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ack", 32'(bus_if.wb_xbus_ack), 32'd0);
    check("rst_rdt", bus_if.wb_xbus_rdt, 32'd0);
    check("rst_irq", 32'(irq_empty), 32'd1);
    @(negedge wb_clk);
    wb_rst_n = 1'b1;

    rd(A_STAT, 32'h0000_0200, "status_reset");
    rd(A_DIV, 32'd104, "div_reset");
    rd(32'h4000_000C, 32'd0, "unmapped_rd");
    rd(A_TX, 32'd0, "txdata_rd");
    miss(32'h0000_0010, 1'b0);
    miss(32'h5000_0000, 1'b1);
    rd(A_STAT, 32'h0000_0200, "status_after_miss");

    // cyc held for three cycles must produce exactly one ack
    @(posedge wb_clk); #1;
    bus_if.wb_dbus_adr = A_DIV;
    bus_if.wb_dbus_we  = 1'b0;
    bus_if.wb_dbus_cyc = 1'b1;
    pulses = 0;
    rdt_at = '0;
    rdt_idle = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge wb_clk); #1;
      if (i == 0) check("held_first_ack", 32'(bus_if.wb_xbus_ack), 32'd1);
      if (bus_if.wb_xbus_ack) begin
        pulses++;
        rdt_at = bus_if.wb_xbus_rdt;
      end else begin
        rdt_idle |= bus_if.wb_xbus_rdt;
      end
    end
    bus_if.wb_dbus_cyc = 1'b0;
    check("held_pulses", 32'(pulses), 32'd1);
    check("held_rdt", rdt_at, 32'd104);
    check("held_rdt_idle", rdt_idle, 32'd0);

    wr(A_DIV, 32'h0000_1234, 4'b0011);
    rd(A_DIV, 32'h0000_1234, "div_full_write");
    wr(A_DIV, 32'h0000_56FF, 4'b0010);
    rd(A_DIV, 32'h0000_5634, "div_lane_gate");
    wr(A_TX, 32'h0000_0077, 4'b0010);
    rd(A_STAT, 32'h0000_0200, "txdata_sel_gate");

    wr(A_DIV, 32'd4, 4'b0011);
    wr(A_TX, 32'h0000_0055, 4'b0001);
    exp_bytes.delete();
    exp_lens.delete();
    add_frame(8'h55, 4);
    fork
      check_stream();
      rd(A_STAT, 32'h0000_0A00, "status_busy");
    join

    wr(A_DIV, 32'd1, 4'b0011);
    rd(A_DIV, 32'd1, "div_one");
    b = 8'($urandom);
    wr(A_TX, {24'b0, b}, 4'b0001);
    exp_bytes.delete();
    exp_lens.delete();
    add_frame(b, 2);
    check_stream();

    wr(A_DIV, 32'd4, 4'b0011);
    wr(A_TX, 32'h0000_00A5, 4'b0001);
    exp_bytes.delete();
    exp_lens.delete();
    add_frame(8'hA5, 4);
    add_frame(8'h3C, 4);
    fork
      check_stream();
      wr(A_TX, 32'h0000_003C, 4'b0001);
    join

    for (int r = 0; r < 4; r++) begin
      d = $urandom_range(0, 7);
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) bq[i] = 8'($urandom);
      wr(A_DIV, 32'(d), 4'b0011);
      exp_bytes.delete();
      exp_lens.delete();
      for (int i = 0; i < n; i++) add_frame(bq[i], eff(d));
      wr(A_TX, {24'b0, bq[0]}, 4'b0001);
      fork
        check_stream();
        for (int i = 1; i < n; i++) wr(A_TX, {24'b0, bq[i]}, 4'b0001);
      join
      rd(A_STAT, 32'h0000_0200, "status_rand_idle");
    end

    wr(A_DIV, 32'd8, 4'b0011);
    b = 8'($urandom);
    wr(A_TX, {24'b0, b}, 4'b0001);
    exp_bytes.delete();
    exp_lens.delete();
    exp_bytes.push_back(b);
    for (int i = 0; i < 10; i++) exp_lens.push_back(i < 5 ? 8 : 4);
    fork
      check_stream();
      begin
        repeat (33) @(posedge wb_clk);
        wr(A_DIV, 32'd4, 4'b0011);
      end
    join

    // Fill the FIFO behind a long all-zero frame, overflow it, clear, then reset mid-frame
    wr(A_DIV, 32'd100, 4'b0011);
    wr(A_TX, 32'h0000_0000, 4'b0001);
    for (int i = 0; i < 16; i++) wr(A_TX, $urandom, 4'b0001);
    rd(A_STAT, 32'h0000_0C10, "status_full");
    wr(A_TX, $urandom, 4'b0001);
    rd(A_STAT, 32'h0001_0C10, "status_overflow");
    wr(A_STAT, 32'h0001_0000, 4'b1011);
    rd(A_STAT, 32'h0001_0C10, "ovf_clear_gated");
    wr(A_STAT, 32'h0001_0000, 4'b0100);
    rd(A_STAT, 32'h0000_0C10, "ovf_cleared");
    check("tx_low_midframe", 32'(tx), 32'd0);

    @(posedge wb_clk); #1;
    bus_if.wb_dbus_adr = A_STAT;
    bus_if.wb_dbus_we  = 1'b0;
    bus_if.wb_dbus_cyc = 1'b1;
    @(posedge wb_clk); #1;
    check("ack_before_rst", 32'(bus_if.wb_xbus_ack), 32'd1);
    #2;
    wb_rst_n = 1'b0;
    #1;
    check("async_rst_tx", 32'(tx), 32'd1);
    check("async_rst_ack", 32'(bus_if.wb_xbus_ack), 32'd0);
    check("async_rst_rdt", bus_if.wb_xbus_rdt, 32'd0);
    check("async_rst_irq", 32'(irq_empty), 32'd1);
    bus_if.wb_dbus_cyc = 1'b0;
    repeat (3) @(posedge wb_clk);
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
    rd(A_STAT, 32'h0000_0200, "status_after_rst");
    rd(A_DIV, 32'd104, "div_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
